// File: rtl/data_memory_bus_pkg.sv
// Shared constants for the data memory bus: peripheral window, register offsets,
// TCON bit positions and the address decoder.
package data_memory_bus_pkg;

    localparam logic [31:0] PERIPH_BASE_DEF = 32'h4000_0000;

    localparam logic [2:0] OFF_TH      = 3'd0;  // byte offset 0x00
    localparam logic [2:0] OFF_TL      = 3'd1;  // 0x04
    localparam logic [2:0] OFF_TCON    = 3'd2;  // 0x08
    localparam logic [2:0] OFF_LED     = 3'd3;  // 0x0C
    localparam logic [2:0] OFF_DIGI    = 3'd4;  // 0x10
    localparam logic [2:0] OFF_SYSTICK = 3'd5;  // 0x14

    localparam int TCON_EN    = 0;
    localparam int TCON_IRQEN = 1;
    localparam int TCON_IRQ   = 2;

    typedef enum logic {
        TMR_STOP = 1'b0,
        TMR_RUN  = 1'b1
    } tmr_state_e;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_TH,
        SEL_TL,
        SEL_TCON,
        SEL_LED,
        SEL_DIGI,
        SEL_SYSTICK
    } bus_sel_e;

    // Full-width compares so the ignored low address bits alias onto the same word.
    function automatic bus_sel_e decode_addr(input logic [31:0] addr,
                                             input logic [31:0] base,
                                             input logic [31:0] ram_bytes);
        logic [31:0] off;
        off = addr - base;
        decode_addr = SEL_NONE;
        if (addr < ram_bytes) begin
            decode_addr = SEL_RAM;
        end else if (off < 32'h18) begin
            case (off[4:2])
                OFF_TH:      decode_addr = SEL_TH;
                OFF_TL:      decode_addr = SEL_TL;
                OFF_TCON:    decode_addr = SEL_TCON;
                OFF_LED:     decode_addr = SEL_LED;
                OFF_DIGI:    decode_addr = SEL_DIGI;
                OFF_SYSTICK: decode_addr = SEL_SYSTICK;
                default:     decode_addr = SEL_NONE;
            endcase
        end
    endfunction

endpackage

// File: rtl/periph_timer.sv
// Reloading up-counter timer with sticky overflow interrupt (TH/TL/TCON).
//   state    | meaning
//   TMR_STOP | TCON.EN=0, TL held
//   TMR_RUN  | TCON.EN=1, TL counts up; all-ones reloads from TH and may raise IRQ
module periph_timer
    import data_memory_bus_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        wr_th_i,
    input  logic        wr_tl_i,
    input  logic        wr_tcon_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] th_o,
    output logic [31:0] tl_o,
    output logic [2:0]  tcon_o,
    output logic        irq_o
);

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    tmr_state_e  state;

    assign state = tmr_state_e'(tcon_q[TCON_EN]);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            th_q   <= '0;
            tl_q   <= '0;
            tcon_q <= '0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
        end
    end

    // Timer update first, CPU writes last so a same-cycle write always wins;
    // reload reads th_q, so a TH write in the reload cycle only affects later reloads.
    always_comb begin
        th_d   = th_q;
        tl_d   = tl_q;
        tcon_d = tcon_q;
        case (state)
            TMR_RUN: begin
                if (tl_q == 32'hFFFF_FFFF) begin
                    tl_d = th_q;
                    if (tcon_q[TCON_IRQEN]) begin
                        tcon_d[TCON_IRQ] = 1'b1;
                    end
                end else begin
                    tl_d = tl_q + 32'd1;
                end
            end
            default: ;
        endcase
        if (wr_th_i)   th_d   = wdata_i;
        if (wr_tl_i)   tl_d   = wdata_i;
        if (wr_tcon_i) tcon_d = wdata_i[2:0];
    end

    assign th_o   = th_q;
    assign tl_o   = tl_q;
    assign tcon_o = tcon_q;
    assign irq_o  = tcon_q[TCON_IRQ];

endmodule

// File: rtl/data_memory_bus.sv
// Data-side memory bus: word RAM, LED/DIGI output registers, free-running SYSTICK
// and the timer, behind a single combinational read mux.
module data_memory_bus
    import data_memory_bus_pkg::*;
#(
    parameter int          RAM_WORDS   = 256,
    parameter logic [31:0] PERIPH_BASE = PERIPH_BASE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    output logic [7:0]  led,
    output logic [11:0] digi,
    output logic        irqout
);

    localparam int          AW        = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

    logic [31:0] ram_q [RAM_WORDS];
    logic [7:0]  led_q, led_d;
    logic [11:0] digi_q, digi_d;
    logic [31:0] systick_q, systick_d;
    logic [31:0] th, tl;
    logic [2:0]  tcon;
    logic [AW-1:0] ram_idx;
    bus_sel_e    sel;

    assign sel     = decode_addr(Address, PERIPH_BASE, RAM_BYTES);
    assign ram_idx = Address[AW+1:2];

    // RAM has no reset; a write presented during reset is still dropped.
    always_ff @(posedge clk) begin
        if (MemWrite && !reset && sel == SEL_RAM) begin
            ram_q[ram_idx] <= Write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_q     <= '0;
            digi_q    <= '0;
            systick_q <= '0;
        end else begin
            led_q     <= led_d;
            digi_q    <= digi_d;
            systick_q <= systick_d;
        end
    end

    always_comb begin
        led_d     = led_q;
        digi_d    = digi_q;
        systick_d = systick_q + 32'd1;
        if (MemWrite) begin
            case (sel)
                SEL_LED:  led_d  = Write_data[7:0];
                SEL_DIGI: digi_d = Write_data[11:0];
                default:  ;
            endcase
        end
    end

    periph_timer u_timer (
        .clk_i     (clk),
        .reset_i   (reset),
        .wr_th_i   (MemWrite && sel == SEL_TH),
        .wr_tl_i   (MemWrite && sel == SEL_TL),
        .wr_tcon_i (MemWrite && sel == SEL_TCON),
        .wdata_i   (Write_data),
        .th_o      (th),
        .tl_o      (tl),
        .tcon_o    (tcon),
        .irq_o     (irqout)
    );

    always_comb begin
        Read_data = 32'h0;
        if (MemRead) begin
            case (sel)
                SEL_RAM:     Read_data = ram_q[ram_idx];
                SEL_TH:      Read_data = th;
                SEL_TL:      Read_data = tl;
                SEL_TCON:    Read_data = {29'd0, tcon};
                SEL_LED:     Read_data = {24'd0, led_q};
                SEL_DIGI:    Read_data = {20'd0, digi_q};
                SEL_SYSTICK: Read_data = systick_q;
                default:     Read_data = 32'h0;
            endcase
        end
    end

    assign led  = led_q;
    assign digi = digi_q;

endmodule

// File: tb/tb_data_memory_bus.sv
// Scoreboard bench for data_memory_bus: stimulus pushes expected values tagged with
// the cycle they apply to; a negedge monitor pops and compares them.
module tb_data_memory_bus;

    localparam logic [31:0] PB     = 32'h4000_0000;
    localparam logic [31:0] TH_A   = PB + 32'h00;
    localparam logic [31:0] TL_A   = PB + 32'h04;
    localparam logic [31:0] TC_A   = PB + 32'h08;
    localparam logic [31:0] LED_A  = PB + 32'h0C;
    localparam logic [31:0] DG_A   = PB + 32'h10;
    localparam logic [31:0] ST_A   = PB + 32'h14;

    localparam int K_RD  = 0;
    localparam int K_LED = 1;
    localparam int K_DG  = 2;
    localparam int K_IRQ = 3;

    typedef struct {
        int          cyc;
        int          kind;
        string       name;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] Address = '0;
    logic [31:0] Write_data = '0;
    logic [31:0] Read_data;
    logic [7:0]  led;
    logic [11:0] digi;
    logic        irqout;

    exp_t sb[$];
    int   cyc = 0;
    int   sys_base = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    data_memory_bus #(.RAM_WORDS(256), .PERIPH_BASE(PB)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Address    (Address),
        .Write_data (Write_data),
        .Read_data  (Read_data),
        .led        (led),
        .digi       (digi),
        .irqout     (irqout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t        e;
            logic [31:0] act;
            e = sb.pop_front();
            case (e.kind)
                K_LED:   act = {24'd0, led};
                K_DG:    act = {20'd0, digi};
                K_IRQ:   act = {31'd0, irqout};
                default: act = Read_data;
            endcase
            n_tests++;
            if (act !== e.val || e.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d, checked at %0d)",
                         e.name, act, e.val, e.cyc, cyc);
            end
        end
    end

    task automatic drive(input logic rst, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk);
        #1;
        reset      = rst;
        MemRead    = rd;
        MemWrite   = wr;
        Address    = a;
        Write_data = wd;
    endtask

    task automatic exp_push(input int kind, input string name, input logic [31:0] v);
        exp_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.name = name;
        e.val  = v;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] systick_model();
        return 32'(cyc - sys_base);
    endfunction

    initial begin
        drive(1, 0, 1, LED_A, 32'hFF);
        drive(1, 0, 0, 0, 0);

        // reset state
        drive(0, 1, 0, ST_A, 0);  sys_base = cyc;
        exp_push(K_RD, "rst_systick", 32'd0);
        exp_push(K_LED, "rst_led", 32'd0);
        exp_push(K_DG, "rst_digi", 32'd0);
        exp_push(K_IRQ, "rst_irq", 32'd0);
        drive(0, 1, 0, TL_A, 0);  exp_push(K_RD, "rst_tl", 32'd0);
        drive(0, 1, 0, TH_A, 0);  exp_push(K_RD, "rst_th", 32'd0);
        drive(0, 1, 0, ST_A, 0);  exp_push(K_RD, "systick_count", systick_model());

        // RAM
        drive(0, 0, 1, 32'h10, 32'hDEADBEEF);
        drive(0, 1, 0, 32'h10, 0);  exp_push(K_RD, "ram_rd", 32'hDEADBEEF);
        drive(0, 1, 0, 32'h13, 0);  exp_push(K_RD, "ram_rd_unaligned", 32'hDEADBEEF);
        drive(0, 1, 1, 32'h10, 32'hCAFEF00D);  exp_push(K_RD, "ram_rw_prewrite", 32'hDEADBEEF);
        drive(0, 1, 0, 32'h10, 0);  exp_push(K_RD, "ram_rw_after", 32'hCAFEF00D);
        drive(0, 0, 1, 32'h0, 32'h11111111);
        drive(0, 0, 1, 32'h400, 32'h22222222);
        drive(0, 0, 1, 32'h3FC, 32'h33333333);
        drive(0, 1, 0, 32'h0, 0);    exp_push(K_RD, "ram_no_alias", 32'h11111111);
        drive(0, 1, 0, 32'h3FC, 0);  exp_push(K_RD, "ram_last_word", 32'h33333333);
        drive(0, 1, 0, 32'h400, 0);  exp_push(K_RD, "ram_past_end", 32'h0);

        // unmapped and no-read
        drive(0, 1, 0, 32'h40000100, 0);  exp_push(K_RD, "unmapped_100", 32'h0);
        drive(0, 1, 0, 32'h40000018, 0);  exp_push(K_RD, "unmapped_18", 32'h0);
        drive(0, 0, 0, 32'h10, 0);        exp_push(K_RD, "noread_ram", 32'h0);

        // LED / DIGI / SYSTICK
        drive(0, 0, 1, LED_A, 32'h1A5);
        drive(0, 0, 1, DG_A, 32'hFABC);
        drive(0, 1, 0, LED_A, 0);
        exp_push(K_RD, "led_readback", 32'hA5);
        exp_push(K_LED, "led_out", 32'hA5);
        exp_push(K_DG, "digi_out", 32'hABC);
        drive(0, 1, 0, DG_A, 0);  exp_push(K_RD, "digi_readback", 32'hABC);
        drive(0, 0, 0, LED_A, 0); exp_push(K_RD, "noread_led", 32'h0);
        drive(0, 1, 1, ST_A, 32'h0);  exp_push(K_RD, "systick_wr_cycle", systick_model());
        drive(0, 1, 0, ST_A, 0);      exp_push(K_RD, "systick_wr_ignored", systick_model());

        // timer reload and sticky IRQ
        drive(0, 0, 1, TH_A, 32'hFFFFFFFE);
        drive(0, 0, 1, TL_A, 32'hFFFFFFFD);
        drive(0, 0, 1, TC_A, 32'd3);
        drive(0, 1, 0, TL_A, 0);  exp_push(K_RD, "tmr_tl0", 32'hFFFFFFFD);
        exp_push(K_IRQ, "tmr_irq0", 32'd0);
        drive(0, 1, 0, TL_A, 0);  exp_push(K_RD, "tmr_tl1", 32'hFFFFFFFE);
        drive(0, 1, 0, TL_A, 0);  exp_push(K_RD, "tmr_tl2", 32'hFFFFFFFF);
        exp_push(K_IRQ, "tmr_irq_pre", 32'd0);
        drive(0, 1, 0, TL_A, 0);  exp_push(K_RD, "tmr_reload", 32'hFFFFFFFE);
        exp_push(K_IRQ, "tmr_irq_set", 32'd1);
        drive(0, 1, 0, TL_A, 0);  exp_push(K_RD, "tmr_tl4", 32'hFFFFFFFF);
        drive(0, 1, 0, TL_A, 0);  exp_push(K_RD, "tmr_reload2", 32'hFFFFFFFE);
        exp_push(K_IRQ, "tmr_irq_sticky", 32'd1);
        drive(0, 1, 1, TC_A, 32'd3);  exp_push(K_RD, "tcon_prewrite", 32'd7);
        drive(0, 1, 0, TC_A, 0);  exp_push(K_RD, "tcon_write_wins", 32'd3);
        exp_push(K_IRQ, "irq_cleared", 32'd0);
        drive(0, 1, 0, TL_A, 0);  exp_push(K_RD, "tmr_tl_after_clr", 32'hFFFFFFFF);
        drive(0, 0, 1, TC_A, 32'd0);  exp_push(K_IRQ, "irq_again", 32'd1);
        drive(0, 1, 0, TL_A, 0);  exp_push(K_RD, "tmr_stop0", 32'hFFFFFFFF);
        exp_push(K_IRQ, "irq_off", 32'd0);
        drive(0, 1, 0, TL_A, 0);  exp_push(K_RD, "tmr_stop_held", 32'hFFFFFFFF);

        // TL write collides with reload
        drive(0, 0, 1, TC_A, 32'd1);
        drive(0, 1, 1, TL_A, 32'd5);  exp_push(K_RD, "coll_pre", 32'hFFFFFFFF);
        drive(0, 1, 0, TL_A, 0);  exp_push(K_RD, "coll_tl_wins", 32'd5);
        exp_push(K_IRQ, "coll_no_irq", 32'd0);
        drive(0, 1, 0, TL_A, 0);  exp_push(K_RD, "coll_tl_inc", 32'd6);

        // TH write collides with reload: old TH is used
        drive(0, 0, 1, TL_A, 32'hFFFFFFFF);
        drive(0, 0, 1, TH_A, 32'h55);
        drive(0, 1, 0, TL_A, 0);  exp_push(K_RD, "th_coll_old", 32'hFFFFFFFE);
        exp_push(K_IRQ, "th_coll_no_irq", 32'd0);
        drive(0, 1, 0, TH_A, 0);  exp_push(K_RD, "th_new", 32'h55);
        drive(0, 0, 1, TC_A, 32'd0);

        // reset mid-run
        drive(0, 0, 1, TL_A, 32'h100);
        drive(0, 0, 1, TC_A, 32'd7);
        drive(0, 1, 0, TC_A, 0);  exp_push(K_RD, "tcon7", 32'd7);
        exp_push(K_IRQ, "irq_tcon7", 32'd1);
        drive(0, 1, 0, TL_A, 0);  exp_push(K_RD, "tl_running", 32'h101);
        drive(1, 0, 1, LED_A, 32'hFF);
        drive(0, 1, 0, TL_A, 0);  sys_base = cyc;
        exp_push(K_RD, "mid_rst_tl", 32'd0);
        exp_push(K_LED, "mid_rst_led", 32'd0);
        exp_push(K_DG, "mid_rst_digi", 32'd0);
        exp_push(K_IRQ, "mid_rst_irq", 32'd0);
        drive(0, 1, 0, TC_A, 0);  exp_push(K_RD, "mid_rst_tcon", 32'd0);
        drive(0, 1, 0, ST_A, 0);  exp_push(K_RD, "mid_rst_systick", systick_model());
        drive(0, 1, 0, TL_A, 0);  exp_push(K_RD, "mid_rst_tl_held", 32'd0);

        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_memory_bus.md
DATA_MEMORY_BUS -- requirements
Module: data_memory_bus

Interface
REQ-001 Parameter: RAM_WORDS, 256, number of 32-bit data RAM words; word addresses use bits [log2(RAM_WORDS)+1:2].
REQ-002 Parameter: PERIPH_BASE, 32'h40000000, base byte address of the peripheral register window.
REQ-003 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-004 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-005 Port: reset  input  1  synchronous active-high reset.
REQ-006 Port: MemRead  input  1  read request from the control path for the current cycle.
REQ-007 Port: MemWrite  input  1  write request from the control path for the current cycle.
REQ-008 Port: Address  input  32  byte address; bits [1:0] ignored.
REQ-009 Port: Write_data  input  32  store data.
REQ-010 Port: Read_data  output  32  load data, combinational.
REQ-011 Port: led  output  8  LED register contents.
REQ-012 Port: digi  output  12  seven-segment register contents.
REQ-013 Port: irqout  output  1  timer interrupt request (equals TCON[2]).

Function
REQ-014 Memory map, SHALL hold: RAM at 0x00000000 .. 4*RAM_WORDS-1; TH at base+0x00; TL at +0x04; TCON at +0x08 (bits [2:0]); LED at +0x0C (bits [7:0]); DIGI at +0x10 (bits [11:0]); SYSTICK at +0x14 (read-only).
REQ-015 Read_data SHALL be the addressed word when MemRead=1, unused register bits read 0; 32'h0 when MemRead=0 or the address is unmapped.
REQ-016 Writes SHALL occur on the rising edge when MemWrite=1; writes to unmapped addresses and to SYSTICK are ignored; upper unused bits of TCON, LED, DIGI discarded.
REQ-017 MemRead and MemWrite both 1: write takes effect at the edge; Read_data in that cycle returns the pre-write value.
REQ-018 SYSTICK SHALL increment by 1 every cycle, wrapping 32'hFFFFFFFF -> 0.
REQ-019 Timer states: STOP (TCON[0]=0): TL held; RUN (TCON[0]=1): TL increments by 1 per cycle.
REQ-020 RUN and TL==32'hFFFFFFFF: next TL SHALL be TH (reload, not 0); if TCON[1]=1, TCON[2] set to 1 on the same edge.
REQ-021 TCON[2] SHALL stay set until software writes TCON; it is never cleared by the timer.
REQ-022 CPU write to TL in the same cycle as increment or reload: CPU value wins.
REQ-023 CPU write to TCON in the same cycle as overflow: written value wins, including bit 2.
REQ-024 CPU write to TH in the same cycle as reload: reload uses the old TH.
REQ-025 irqout, led, digi SHALL be direct register outputs (no combinational path from inputs).

Reset
REQ-026 On reset: TH, TL, TCON, LED, DIGI, SYSTICK = 0; irqout=0, led=0, digi=0; in-flight write in the reset cycle discarded.
REQ-027 RAM contents SHALL NOT be reset; reads of unwritten RAM are undefined for verification.

Structure
REQ-028 Shared constants header SHALL hold PERIPH_BASE, register offsets and TCON bit indices (EN=0, IRQEN=1, IRQ=2).
REQ-029 Timer (TH/TL/TCON, reload, IRQ) SHALL be a sub-module named periph_timer; RAM, LED, DIGI, SYSTICK and decode stay in data_memory_bus.

Verification
REQ-030 RAM: write 0xDEADBEEF to 0x00000010, then MemRead same address -> Read_data=0xDEADBEEF; Address 0x00000013 -> same word.
REQ-031 Timer: TH=0xFFFFFFFE, TL=0xFFFFFFFD, TCON=3 -> TL: FFFFFFFE, FFFFFFFF, FFFFFFFE; irqout rises on the reload edge and stays 1 until TCON written 3.
REQ-032 Collision: TCON=1, TL=0xFFFFFFFF, same cycle write TL=5 -> TL=5 next cycle, then 6; no IRQ.
REQ-033 Peripherals: write LED 0x1A5, DIGI 0xFABC -> led=0xA5, digi=0xABC; read back LED -> 0x000000A5; write SYSTICK ignored, SYSTICK advances by 1 per cycle.
REQ-034 Reset mid-run: TCON=7, TL counting, assert reset one cycle -> TL, TCON, SYSTICK, led, digi, irqout all 0 next cycle; TL holds 0 afterwards.
REQ-035 Unmapped/no-read: MemRead=1 at 0x40000100 -> Read_data=0; MemRead=0 at any mapped address -> Read_data=0.
